irq_controller: RTL and testbench

// - Platform interrupt controller directly upstream of the exception unit; drives its single `interrupt` input.
// - Synchronises NUM_SRC asynchronous external request lines and latches them as level- or edge-triggered pending bits.
// - Presents one prioritised request and runs an ack / claim / complete handshake so each interrupt is serviced exactly once.
// - mstatus.MIE gating stays downstream; this block never looks at it.

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_sync.sv | 38 +++
 rtl/irq_controller.sv | 173 +++++++++++++++++
 tb/tb_irq_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the platform interrupt controller: register
// offsets, handshake state encoding and the claim ID width.
package irq_pkg;

    localparam logic [3:0] IRQ_ENABLE  = 4'h0;
    localparam logic [3:0] IRQ_EDGE    = 4'h4;
    localparam logic [3:0] IRQ_PENDING = 4'h8;
    localparam logic [3:0] IRQ_CLAIM   = 4'hC;

    localparam int IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous request line, followed by a
// one-cycle delay so a rising edge of the synchronised level can be flagged.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   delay_q;
    logic                   delay_d;

    // Shift the raw input through the synchroniser chain and keep the previous level.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        delay_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay flops, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            delay_q <= delay_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: synchronises external request lines,
// latches them as level or edge pending bits, picks the lowest-index enabled
// request and runs the ack / claim / complete handshake with the core.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                irq_ack,
    input  logic                cfg_we,
    input  logic                cfg_re,
    input  logic [3:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic                interrupt,
    output logic [IRQ_ID_W-1:0] irq_id
);

    logic [NUM_SRC-1:0]  s_lvl;
    logic [NUM_SRC-1:0]  s_rise;

    logic [NUM_SRC-1:0]  enable_q,  enable_d;
    logic [NUM_SRC-1:0]  edge_q,    edge_d;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    irq_state_e          state_q,   state_d;
    logic                interrupt_q, interrupt_d;
    logic [IRQ_ID_W-1:0] irq_id_q,  irq_id_d;

    logic [NUM_SRC-1:0]  req;
    logic [NUM_SRC-1:0]  win_mask;
    logic [IRQ_ID_W-1:0] win_id;
    logic [NUM_SRC-1:0]  clr_mask;
    logic [NUM_SRC-1:0]  wdata_src;

    logic wr_enable;
    logic wr_edge;
    logic wr_pending;
    logic ack_take;
    logic claim_done;
    logic unused_cfg;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (irq_src[i]),
            .sync_out (s_lvl[i]),
            .rise     (s_rise[i])
        );
    end

    // Reads have no side effects, so the read strobe and unused write bits are only sunk here.
    assign unused_cfg = ^{cfg_re, cfg_wdata};

    assign wdata_src  = cfg_wdata[NUM_SRC-1:0];
    assign wr_enable  = cfg_we && (cfg_addr == IRQ_ENABLE);
    assign wr_edge    = cfg_we && (cfg_addr == IRQ_EDGE);
    assign wr_pending = cfg_we && (cfg_addr == IRQ_PENDING);
    assign ack_take   = (state_q == ASSERT) && irq_ack;
    assign claim_done = (state_q == SERVICE) && cfg_we && (cfg_addr == IRQ_CLAIM) &&
                        (cfg_wdata[IRQ_ID_W-1:0] == irq_id_q);

    assign req = pending_q & enable_q;

    // Priority encoder: scanning downward lets the lowest requesting index win.
    always_comb begin
        win_id   = '0;
        win_mask = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id      = IRQ_ID_W'(i + 1);
                win_mask    = '0;
                win_mask[i] = 1'b1;
            end
        end
    end

    // Register file next values; edge pending bits give a new edge priority over any clear.
    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        if (wr_enable) begin
            enable_d = wdata_src;
        end
        if (wr_edge) begin
            edge_d = wdata_src;
        end
        clr_mask  = (wr_pending ? wdata_src : '0) | (ack_take ? win_mask : '0);
        pending_d = (edge_q & (s_rise | (pending_q & ~clr_mask))) | (~edge_q & s_lvl);
        if (wr_edge) begin
            pending_d = pending_d & ~(edge_q ^ wdata_src);
        end
    end

    // Handshake next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                end else if (req == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (claim_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs: interrupt follows the upcoming state, irq_id latches on ack.
    always_comb begin
        interrupt_d = (state_d == ASSERT);
        irq_id_d    = irq_id_q;
        if (ack_take) begin
            irq_id_d = win_id;
        end else if (claim_done) begin
            irq_id_d = '0;
        end
    end

    // All controller state, cleared together by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enable_q    <= '0;
            edge_q      <= '0;
            pending_q   <= '0;
            state_q     <= IDLE;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            enable_q    <= enable_d;
            edge_q      <= edge_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            irq_id_q    <= irq_id_d;
        end
    end

    // MMIO read mux, combinational from the offset; unmapped offsets read zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            IRQ_ENABLE:  cfg_rdata = {{(32-NUM_SRC){1'b0}}, enable_q};
            IRQ_EDGE:    cfg_rdata = {{(32-NUM_SRC){1'b0}}, edge_q};
            IRQ_PENDING: cfg_rdata = {{(32-NUM_SRC){1'b0}}, pending_q};
            IRQ_CLAIM:   cfg_rdata = {{(32-IRQ_ID_W){1'b0}}, irq_id_q};
            default:     cfg_rdata = '0;
        endcase
    end

    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed handshake scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a behavioural model of the controller.
module tb_irq_controller;

    localparam int NUM_SRC     = 8;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        irq_ack;
    logic        cfg_we;
    logic        cfg_re;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        interrupt;
    logic [4:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [7:0] m_en       = '0;
    logic [7:0] m_edge     = '0;
    logic [7:0] m_pend     = '0;
    bit         m_waiting  = 1'b0;
    bit         m_serving  = 1'b0;
    int         m_id       = 0;
    logic [7:0] hist[$];

    irq_controller #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .irq_ack   (irq_ack),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .interrupt (interrupt),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: pending rules and handshake evaluated from the pre-edge view of all inputs.
    always @(posedge clk) begin : model
        logic [7:0] s, sd, req, clr, np;
        int win, n;
        if (!rst) begin
            m_en = '0; m_edge = '0; m_pend = '0;
            m_waiting = 1'b0; m_serving = 1'b0; m_id = 0;
            hist.delete();
            for (int k = 0; k <= SYNC_STAGES; k++) hist.push_back(8'h00);
        end else begin
            n   = hist.size();
            s   = hist[n - SYNC_STAGES];
            sd  = hist[n - SYNC_STAGES - 1];
            req = m_pend & m_en;
            win = 0;
            for (int i = NUM_SRC - 1; i >= 0; i--) if (req[i]) win = i + 1;
            clr = '0;
            if (cfg_we && cfg_addr == 4'h8) clr = cfg_wdata[7:0];
            if (m_waiting && irq_ack && win != 0) clr[win-1] = 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (m_edge[i]) np[i] = (s[i] & ~sd[i]) | (m_pend[i] & ~clr[i]);
                else           np[i] = s[i];
            end
            if (cfg_we && cfg_addr == 4'h4) np = np & ~(m_edge ^ cfg_wdata[7:0]);
            if (m_waiting) begin
                if (irq_ack) begin
                    m_id = win; m_waiting = 1'b0; m_serving = 1'b1;
                end else if (req == 0) begin
                    m_waiting = 1'b0;
                end
            end else if (m_serving) begin
                if (cfg_we && cfg_addr == 4'hC && int'(cfg_wdata[4:0]) == m_id) begin
                    m_id = 0; m_serving = 1'b0;
                end
            end else if (req != 0) begin
                m_waiting = 1'b1;
            end
            if (cfg_we && cfg_addr == 4'h0) m_en   = cfg_wdata[7:0];
            if (cfg_we && cfg_addr == 4'h4) m_edge = cfg_wdata[7:0];
            m_pend = np;
            hist.push_back(irq_src);
            void'(hist.pop_front());
        end
    end

    // Compare process: every cycle, outputs and read data against the model.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        if (chk_en) begin
            case (cfg_addr)
                4'h0:    exp_rd = {24'h0, m_en};
                4'h4:    exp_rd = {24'h0, m_edge};
                4'h8:    exp_rd = {24'h0, m_pend};
                4'hC:    exp_rd = 32'(m_id);
                default: exp_rd = 32'h0;
            endcase
            checkOutput("model_interrupt", {31'h0, interrupt}, {31'h0, m_waiting});
            checkOutput("model_irq_id", {27'h0, irq_id}, 32'(m_id));
            checkOutput("model_rdata", cfg_rdata, exp_rd);
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        cycle();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfgRead(input logic [3:0] addr, output logic [31:0] data);
        cfg_re = 1'b1; cfg_addr = addr;
        #1;
        data = cfg_rdata;
        cfg_re = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        cfgRead(addr, d);
        checkOutput(name, d, expected);
    endtask

    task automatic ackPulse();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    task automatic waitInterrupt(input logic level, input string name);
        for (int k = 0; k < 12 && interrupt !== level; k++) cycle();
        checkOutput(name, {31'h0, interrupt}, {31'h0, level});
    endtask

    initial begin
        rst = 1'b0; irq_src = 8'hFF; irq_ack = 1'b0;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 4'h0; cfg_wdata = '0;

        // 1. Reset with all sources high
        @(posedge clk);
        chk_en = 1'b1;
        cycle(); cycle(); cycle();
        checkOutput("rst_interrupt", {31'h0, interrupt}, 32'h0);
        checkOutput("rst_irq_id", {27'h0, irq_id}, 32'h0);
        readCheck("rst_enable", 4'h0, 32'h0);
        readCheck("rst_edge", 4'h4, 32'h0);
        readCheck("rst_pending", 4'h8, 32'h0);
        readCheck("rst_claim", 4'hC, 32'h0);
        irq_src = 8'h00; rst = 1'b1;
        for (int k = 0; k < 5; k++) cycle();

        // 2. Edge source 2: latency, ack, complete
        applyStimulus(4'h0, 32'h04);
        applyStimulus(4'h4, 32'h04);
        irq_src = 8'h04;
        cycle();
        irq_src = 8'h00;
        cycle(); cycle();
        checkOutput("lat_early", {31'h0, interrupt}, 32'h0);
        cycle();
        checkOutput("lat_rise", {31'h0, interrupt}, 32'h1);
        ackPulse();
        checkOutput("t2_irq_id", {27'h0, irq_id}, 32'd3);
        checkOutput("t2_int_low", {31'h0, interrupt}, 32'h0);
        readCheck("t2_pending", 4'h8, 32'h0);
        readCheck("t2_claim_rd", 4'hC, 32'd3);
        applyStimulus(4'hC, 32'd3);
        checkOutput("t2_done_id", {27'h0, irq_id}, 32'h0);

        // 3. Priority between level sources 5 and 1
        applyStimulus(4'h0, 32'hFF);
        applyStimulus(4'h4, 32'h00);
        irq_src = 8'h22;
        waitInterrupt(1'b1, "t3_assert");
        ackPulse();
        checkOutput("t3_id_first", {27'h0, irq_id}, 32'd2);
        applyStimulus(4'hC, 32'd2);
        waitInterrupt(1'b1, "t3_reassert");
        ackPulse();
        checkOutput("t3_id_again", {27'h0, irq_id}, 32'd2);
        applyStimulus(4'hC, 32'd2);
        irq_src = 8'h00;
        for (int k = 0; k < 8; k++) cycle();
        checkOutput("t3_quiet", {31'h0, interrupt}, 32'h0);

        // 4. Level drop before ack
        applyStimulus(4'h0, 32'h01);
        irq_src = 8'h01;
        waitInterrupt(1'b1, "t4_assert");
        irq_src = 8'h00;
        waitInterrupt(1'b0, "t4_drop");
        checkOutput("t4_no_claim", {27'h0, irq_id}, 32'h0);

        // 5. Same-cycle ack and edge on source 1, then edge on source 3 during service
        applyStimulus(4'h4, 32'h0A);
        applyStimulus(4'h0, 32'h0A);
        irq_src = 8'h02;
        cycle();
        irq_src = 8'h00;
        waitInterrupt(1'b1, "t5_assert");
        irq_src = 8'h02;
        cycle();
        irq_src = 8'h00;
        cycle();
        ackPulse();
        checkOutput("t5_id", {27'h0, irq_id}, 32'd2);
        readCheck("t5_set_wins", 4'h8, 32'h02);
        irq_src = 8'h08;
        cycle();
        irq_src = 8'h00;
        for (int k = 0; k < 4; k++) cycle();
        checkOutput("t5_no_nest", {31'h0, interrupt}, 32'h0);
        readCheck("t5_pend_both", 4'h8, 32'h0A);
        applyStimulus(4'hC, 32'd2);
        waitInterrupt(1'b1, "t5_reassert");
        ackPulse();
        checkOutput("t5_id_src1", {27'h0, irq_id}, 32'd2);
        applyStimulus(4'hC, 32'd2);
        waitInterrupt(1'b1, "t5_src3_assert");
        ackPulse();
        checkOutput("t5_id_src3", {27'h0, irq_id}, 32'd4);
        applyStimulus(4'hC, 32'd4);
        readCheck("t5_pend_clear", 4'h8, 32'h0);

        // 6. Mismatched complete, then reset during service
        applyStimulus(4'h4, 32'h00);
        applyStimulus(4'h0, 32'h02);
        irq_src = 8'h02;
        waitInterrupt(1'b1, "t6_assert");
        ackPulse();
        applyStimulus(4'hC, 32'd7);
        checkOutput("t6_bad_claim", {27'h0, irq_id}, 32'd2);
        checkOutput("t6_bad_int", {31'h0, interrupt}, 32'h0);
        rst = 1'b0;
        cycle();
        checkOutput("t6_rst_id", {27'h0, irq_id}, 32'h0);
        readCheck("t6_rst_enable", 4'h0, 32'h0);
        rst = 1'b1; irq_src = 8'h00;
        for (int k = 0; k < 4; k++) cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ 8'($urandom_range(0, 255));
            irq_ack = (m_waiting && $urandom_range(0, 2) == 0) || ($urandom_range(0, 30) == 0);
            cfg_we = 1'b0; cfg_wdata = '0;
            cfg_addr = 4'($urandom_range(0, 15));
            if (m_serving && $urandom_range(0, 4) == 0) begin
                cfg_we = 1'b1; cfg_addr = 4'hC;
                cfg_wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : 32'(m_id);
            end else if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = 4'($urandom_range(0, 3) * 4);
                cfg_wdata = $urandom;
            end
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        cfg_we = 1'b0; irq_ack = 1'b0; rst = 1'b1;
        cycle();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
